// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU result producer, alu_result_fifo and writeback.
// Optional parity signals exist only when ALU_RES_PARITY_EN is defined.
interface alu_result_fifo_if #(
  parameter int RES_W = 6,
  parameter int OP_W  = 3,
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] in_res;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_res;
  logic [OP_W-1:0]  out_op;
  logic             out_zero;
  logic [CNT_W-1:0] count;
  logic [7:0]       drop_cnt;
`ifdef ALU_RES_PARITY_EN
  logic             out_par;
  logic             chk_en;
  logic             par_err;
`endif

  // Producer/consumer environment side.
  modport master (
    output in_valid, in_res, in_op, out_ready,
`ifdef ALU_RES_PARITY_EN
    output chk_en,
    input  out_par, par_err,
`endif
    input  in_ready, out_valid, out_res, out_op, out_zero, count, drop_cnt
  );

  // FIFO side.
  modport slave (
    input  in_valid, in_res, in_op, out_ready,
`ifdef ALU_RES_PARITY_EN
    input  chk_en,
    output out_par, par_err,
`endif
    output in_ready, out_valid, out_res, out_op, out_zero, count, drop_cnt
  );
endinterface

// File: rtl/alu_result_fifo.sv
// Registered FIFO buffering ALU results, opcode tags and per-entry zero flags for writeback.
// Optional per-entry parity with sticky check: define ALU_RES_PARITY_EN.
module alu_result_fifo #(
  parameter int RES_W = 6,
  parameter int OP_W  = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic               clk,
  input logic               rst,
  alu_result_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [RES_W-1:0] res;
    logic [OP_W-1:0]  op;
    logic             zero;
`ifdef ALU_RES_PARITY_EN
    logic             par;
`endif
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       drop_cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && bus.out_ready;

  // Zero flag and parity are derived once at write time and travel with the entry.
  always_comb begin
    wr_entry      = '0;
    wr_entry.res  = bus.in_res;
    wr_entry.op   = bus.in_op;
    wr_entry.zero = (bus.in_res == '0);
`ifdef ALU_RES_PARITY_EN
    wr_entry.par  = ^bus.in_res;
`endif
  end

  // NOTE: the storage array has no reset; occupancy tracking alone decides what is valid,
  // which keeps the array a plain RAM instead of DEPTH resettable registers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (bus.in_valid && full && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Head fields read as zero while empty so downstream never sees stale contents.
  assign head          = mem[rd_ptr];
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_res   = empty ? '0 : head.res;
  assign bus.out_op    = empty ? '0 : head.op;
  assign bus.out_zero  = empty ? 1'b0 : head.zero;
  assign bus.count     = count;
  assign bus.drop_cnt  = drop_cnt;

`ifdef ALU_RES_PARITY_EN
  logic par_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err <= 1'b0;
    end else if (pop && bus.chk_en && (head.par != ^head.res)) begin
      par_err <= 1'b1;
    end
  end

  assign bus.out_par = empty ? 1'b0 : head.par;
  assign bus.par_err = par_err;
`endif
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the ALU logic units (Or_, and siblings). Captures each ALU result together with its opcode tag into a small FIFO.
- Generates a zero flag per entry and presents results to the writeback/register-file stage over a valid/ready handshake.
- Decouples single-cycle ALU output from writeback stalls.

Parameters:
- RES_W, 6, result width; matches the ALU 2x operand-width result (3-bit operands -> 6-bit result).
- OP_W, 3, opcode tag width carried alongside each result.
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- CNT_W, 3, occupancy counter width = log2(DEPTH)+1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result valid this cycle.
- in_ready  out  1  FIFO can accept; equals !full.
- in_res  in  RES_W  ALU result.
- in_op  in  OP_W  opcode tag of the producing operation.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  writeback accepts head.
- out_res  out  RES_W  head result.
- out_op  out  OP_W  head opcode tag.
- out_zero  out  1  head result == 0.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- drop_cnt  out  8  saturating count of cycles with in_valid && !in_ready.

Behaviour:
- Reset (async assert, sync-safe deassert): wr_ptr=0, rd_ptr=0, count=0, drop_cnt=0, out_valid=0, in_ready=1. out_res/out_op/out_zero read as 0 while empty.
- Push = in_valid && in_ready; pop = out_valid && out_ready. Both are evaluated on the rising edge.
- Storage is registered, with no empty bypass. A pushed entry appears on out_* one cycle after the push edge, so minimum latency is 1 cycle.
- out_zero is computed at write time (in_res == 0) and stored per entry.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. full = (count == DEPTH); empty = (count == 0).
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; both pointers advance
  - neither: hold
- Full: in_ready=0 and push is ignored. A simultaneous pop when full frees a slot next cycle only; no same-cycle pass-through.
- Empty: out_valid=0 and out_ready is ignored. count never underflows or overflows.
- drop_cnt increments on each cycle with in_valid && !in_ready, and saturates at 255.
- out_* hold stable while out_valid && !out_ready. Entries are delivered strictly in push order.
- Reset mid-operation: all contents are discarded immediately (async), and outputs return to reset values in the same cycle reset asserts.

Optional Feature:
- Macro ALU_RES_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit), the even parity (XOR reduction) of the head out_res, computed at write time and stored per entry.
  - Adds input chk_en. When chk_en=1, a sticky output par_err (1 bit, reset 0) sets if the stored parity differs from the recomputed parity of the head at pop.
- Undefined: no parity storage and no out_par/chk_en/par_err ports. Behaviour is otherwise identical.

Test Plan:
1. Reset then single push: in_res=6'b000101 (101|100), in_op=3'd2 -> next cycle out_valid=1, out_res=000101, out_op=2, out_zero=0, count=1. Pop with out_ready=1 -> count=0, out_valid=0.
2. Zero flag: push 6'b000000 (101&010 result) -> out_zero=1. Then push 6'b000111 (110|101) -> after first pop, out_zero=0, out_res=000111.
3. Fill and overflow: out_ready=0, push 000101, 000101, 000111, 000111 -> count=4, in_ready=0. Hold in_valid 3 more cycles -> drop_cnt=3, contents unchanged. Drain -> order 000101, 000101, 000111, 000111.
4. Simultaneous push/pop at count=2 with pointers wrapped (after 5 prior pushes) -> count stays 2 and FIFO order is preserved across the wrap.
5. Backpressure: out_ready toggles 0/1 each cycle while pushing 8 values 1..8 -> all 8 are delivered in order, out_* stable during stalls, no drops.
6. Reset asserted mid-stream at count=3 -> same cycle out_valid=0, count=0, drop_cnt=0. After release, push 000001 -> delivered 1 cycle later.
